// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller sharing one hex decoder across all digits.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LEADING_ZERO_BLANK_EN.

module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 1000,
    parameter int unsigned BLANK_CYC  = 4,
    localparam int unsigned AW        = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [AW-1:0]         load_addr,
    input  logic [3:0]            load_data,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [3:0]            dec_din,
    input  logic [7:0]            dec_seg,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_done
);

    localparam int unsigned CW        = $clog2(PRESCALE);
    localparam int unsigned DRIVE_CYC = PRESCALE - BLANK_CYC;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBlank = 2'd1;
    localparam logic [1:0] StDrive = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d, idx_nxt;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            dec_din_q, dec_din_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;
    logic [3:0]            digit_q [NUM_DIGITS];
    logic [6:0]            seg_body;

    // The decoder's dp output is not used; dp comes from dp_mask.
    logic unused_dec_dp;
    assign unused_dec_dp = dec_seg[7];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) digit_q[i] <= 4'h0;
        end else if (load && (32'(load_addr) < NUM_DIGITS)) begin
            digit_q[load_addr] <= load_data;
        end
    end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    // upper_zero[i] is set when digit i and every higher digit hold zero.
    logic [NUM_DIGITS-1:0] upper_zero;
    always_comb begin
        logic run;
        upper_zero = '0;
        run = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            run = run & (digit_q[i] == 4'h0);
            upper_zero[i] = run;
        end
    end
    assign seg_body = ((idx_q != '0) && upper_zero[idx_q]) ? 7'h00 : dec_seg[6:0];
`else
    assign seg_body = dec_seg[6:0];
`endif

    assign idx_nxt = (idx_q == AW'(NUM_DIGITS - 1)) ? '0 : idx_q + AW'(1);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        dec_din_d    = dec_din_q;
        seg_d        = seg_q;
        an_d         = an_q;
        frame_done_d = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
            seg_d   = '0;
            an_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d   = StBlank;
                    idx_d     = '0;
                    cnt_d     = '0;
                    dec_din_d = digit_q[0];
                    seg_d     = '0;
                    an_d      = '0;
                end
                StBlank: begin
                    if (cnt_q == CW'(BLANK_CYC - 1)) begin
                        state_d = StDrive;
                        cnt_d   = '0;
                        an_d    = NUM_DIGITS'(1) << idx_q;
                        seg_d   = {dp_mask[idx_q], seg_body};
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StDrive: begin
                    if (cnt_q == CW'(DRIVE_CYC - 1)) begin
                        state_d      = StBlank;
                        cnt_d        = '0;
                        idx_d        = idx_nxt;
                        dec_din_d    = digit_q[idx_nxt];
                        an_d         = '0;
                        seg_d        = '0;
                        frame_done_d = (idx_q == AW'(NUM_DIGITS - 1));
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = '0;
                    cnt_d   = '0;
                    seg_d   = '0;
                    an_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            dec_din_q    <= 4'h0;
            seg_q        <= 8'h00;
            an_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            dec_din_q    <= dec_din_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dec_din    = dec_din_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: position-in-frame reference model, directed scenarios and random traffic.

module tb_seg_scan_ctrl;

    localparam int N = 4;
    localparam int P = 8;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       load;
    logic [1:0] load_addr;
    logic [3:0] load_data;
    logic [3:0] dp_mask;
    logic [3:0] dec_din;
    logic [7:0] dec_seg;
    logic [7:0] seg;
    logic [3:0] an;
    logic       frame_done;

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  4'hF: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    // Decoder dp output forced high so a design that leaks it is caught.
    assign dec_seg = {1'b1, hex7(dec_din)};

    seg_scan_ctrl #(
        .NUM_DIGITS (N),
        .PRESCALE   (P),
        .BLANK_CYC  (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .dp_mask    (dp_mask),
        .dec_din    (dec_din),
        .dec_seg    (dec_seg),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;

    // Model: k counts cycles since the enabling edge; slot = k/P, position in slot = k%P.
    int         k = -1;
    logic [3:0] mdig [N];
    logic [3:0] snap = 4'h0;
    logic       dp_s = 1'b0;
    logic       lz_s = 1'b0;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic       exp_fd;

    function automatic logic lead_zero(input int d);
        logic all_zero;
        logic feature_on;
        all_zero = 1'b1;
        for (int j = d; j < N; j++) if (mdig[j] != 4'h0) all_zero = 1'b0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        feature_on = 1'b1;
`else
        feature_on = 1'b0;
`endif
        return feature_on && (d > 0) && all_zero;
    endfunction

    task automatic tick();
        int pos;
        int dg;
        pos = 0;
        dg  = 0;
        if (!rst) begin
            for (int i = 0; i < N; i++) mdig[i] = 4'h0;
            k    = -1;
            snap = 4'h0;
            dp_s = 1'b0;
            lz_s = 1'b0;
        end else begin
            if (enable) begin
                k   = (k < 0) ? 0 : k + 1;
                pos = k % P;
                dg  = (k / P) % N;
                if (pos == 0) snap = mdig[dg];
                if (pos == B) begin
                    dp_s = dp_mask[dg];
                    lz_s = lead_zero(dg);
                end
            end else begin
                k = -1;
            end
            if (load && int'(load_addr) < N) mdig[load_addr] = load_data;
        end
        @(posedge clk);
        #1;
        if (k >= 0 && pos >= B) begin
            exp_an  = 4'b0001 << dg;
            exp_seg = {dp_s, lz_s ? 7'h00 : hex7(snap)};
        end else begin
            exp_an  = 4'b0000;
            exp_seg = 8'h00;
        end
        exp_fd = (k > 0) && (k % (N * P) == 0);
    endtask

    task automatic go_idle();
        enable = 1'b0;
        load   = 1'b0;
        tick();
    endtask

    task automatic load_digit(input logic [1:0] a, input logic [3:0] d);
        load      = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; load = 1'b1; load_addr = 2'd2; load_data = 4'h7; dp_mask = 4'hF;
        repeat (2) begin
            tick();
            checks++;
            if ({an, seg, frame_done, dec_din} !== 17'h0) begin
                errors++;
                $display("FAIL reset_outputs: got an=%b seg=%h fd=%b din=%h, want all zero",
                         an, seg, frame_done, dec_din);
            end
        end
        rst = 1'b1; load = 1'b0; dp_mask = 4'h0;
        repeat (N * P + 1) begin
            tick();
            checks++;
            if ({an, seg, frame_done, dec_din} !== {exp_an, exp_seg, exp_fd, snap}) begin
                errors++;
                $display("FAIL reset_regs k=%0d: got an=%b seg=%h fd=%b din=%h, want an=%b seg=%h fd=%b din=%h",
                         k, an, seg, frame_done, dec_din, exp_an, exp_seg, exp_fd, snap);
            end
        end
    endtask

    task automatic test_basic_scan();
        int pulses;
        pulses = 0;
        go_idle();
        for (int i = 0; i < N; i++) load_digit(2'(i), 4'(i + 1));
        dp_mask = 4'h0;
        enable  = 1'b1;
        repeat (2 * N * P + 1) begin
            tick();
            if (frame_done === 1'b1) pulses++;
            checks++;
            if ({an, seg, frame_done, dec_din} !== {exp_an, exp_seg, exp_fd, snap}) begin
                errors++;
                $display("FAIL basic_scan k=%0d: got an=%b seg=%h fd=%b din=%h, want an=%b seg=%h fd=%b din=%h",
                         k, an, seg, frame_done, dec_din, exp_an, exp_seg, exp_fd, snap);
            end
        end
        checks++;
        if (pulses !== 2) begin
            errors++;
            $display("FAIL frame_done_count: got %0d pulses, want 2", pulses);
        end
    endtask

    task automatic test_dp();
        int dp_hits;
        int dp_wrong;
        dp_hits  = 0;
        dp_wrong = 0;
        dp_mask  = 4'b0100;
        repeat (N * P) begin
            tick();
            if (seg[7] === 1'b1) begin
                dp_hits++;
                if (an !== 4'b0100) dp_wrong++;
            end
            checks++;
            if ({an, seg, frame_done, dec_din} !== {exp_an, exp_seg, exp_fd, snap}) begin
                errors++;
                $display("FAIL dp k=%0d: got an=%b seg=%h fd=%b din=%h, want an=%b seg=%h fd=%b din=%h",
                         k, an, seg, frame_done, dec_din, exp_an, exp_seg, exp_fd, snap);
            end
        end
        checks++;
        if (dp_hits !== P - B || dp_wrong !== 0) begin
            errors++;
            $display("FAIL dp_window: got %0d dp cycles (%0d off-digit), want %0d (0)",
                     dp_hits, dp_wrong, P - B);
        end
        dp_mask = 4'h0;
    endtask

    task automatic test_snapshot();
        go_idle();
        dp_mask = 4'h0;
        enable  = 1'b1;
        for (int c = 0; c < 2 * N * P; c++) begin
            load      = (c == P + B + 2);
            load_addr = 2'd1;
            load_data = 4'h9;
            tick();
            checks++;
            if ({an, seg, frame_done, dec_din} !== {exp_an, exp_seg, exp_fd, snap}) begin
                errors++;
                $display("FAIL snapshot k=%0d: got an=%b seg=%h fd=%b din=%h, want an=%b seg=%h fd=%b din=%h",
                         k, an, seg, frame_done, dec_din, exp_an, exp_seg, exp_fd, snap);
            end
            if (c == P + B + 3) begin
                checks++;
                if (seg !== 8'h5B) begin
                    errors++;
                    $display("FAIL snapshot_old: got seg=%h, want 5b", seg);
                end
            end
            if (c == N * P + P + B + 1) begin
                checks++;
                if (seg !== 8'h6F) begin
                    errors++;
                    $display("FAIL snapshot_new: got seg=%h, want 6f", seg);
                end
            end
        end
        load = 1'b0;
    endtask

    task automatic test_enable_drop();
        go_idle();
        enable = 1'b1;
        repeat (2 * P + B + 3) begin
            tick();
            checks++;
            if ({an, seg, frame_done, dec_din} !== {exp_an, exp_seg, exp_fd, snap}) begin
                errors++;
                $display("FAIL pre_drop k=%0d: got an=%b seg=%h fd=%b din=%h, want an=%b seg=%h fd=%b din=%h",
                         k, an, seg, frame_done, dec_din, exp_an, exp_seg, exp_fd, snap);
            end
        end
        enable = 1'b0;
        tick();
        checks++;
        if ({an, seg, frame_done} !== 13'h0 || {an, seg, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
            errors++;
            $display("FAIL enable_drop: got an=%b seg=%h fd=%b, want all zero", an, seg, frame_done);
        end
        enable = 1'b1;
        for (int c = 0; c < N * P; c++) begin
            tick();
            checks++;
            if ({an, seg, frame_done, dec_din} !== {exp_an, exp_seg, exp_fd, snap}) begin
                errors++;
                $display("FAIL re_enable k=%0d: got an=%b seg=%h fd=%b din=%h, want an=%b seg=%h fd=%b din=%h",
                         k, an, seg, frame_done, dec_din, exp_an, exp_seg, exp_fd, snap);
            end
            if (c == 2) begin
                checks++;
                if (an !== 4'b0001) begin
                    errors++;
                    $display("FAIL re_enable_first_an: got an=%b, want 0001", an);
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [7:0] want_hi;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        want_hi = 8'h00;
`else
        want_hi = 8'h3F;
`endif
        go_idle();
        load_digit(2'd0, 4'h5);
        load_digit(2'd1, 4'h0);
        load_digit(2'd2, 4'h0);
        load_digit(2'd3, 4'h0);
        dp_mask = 4'h0;
        enable  = 1'b1;
        for (int c = 0; c < N * P; c++) begin
            tick();
            checks++;
            if ({an, seg, frame_done, dec_din} !== {exp_an, exp_seg, exp_fd, snap}) begin
                errors++;
                $display("FAIL leading_zero k=%0d: got an=%b seg=%h fd=%b din=%h, want an=%b seg=%h fd=%b din=%h",
                         k, an, seg, frame_done, dec_din, exp_an, exp_seg, exp_fd, snap);
            end
            if (c == B) begin
                checks++;
                if (seg !== 8'h6D || an !== 4'b0001) begin
                    errors++;
                    $display("FAIL lz_digit0: got an=%b seg=%h, want 0001 6d", an, seg);
                end
            end
            if (c == 3 * P + B) begin
                checks++;
                if (seg !== want_hi || an !== 4'b1000) begin
                    errors++;
                    $display("FAIL lz_digit3: got an=%b seg=%h, want 1000 %h", an, seg, want_hi);
                end
            end
        end
    endtask

    task automatic test_random();
        go_idle();
        enable = 1'b1;
        repeat (3000) begin
            rst       = ($urandom_range(0, 999) != 0);
            enable    = ($urandom_range(0, 199) != 0);
            load      = ($urandom_range(0, 7) == 0);
            load_addr = 2'($urandom_range(0, 3));
            load_data = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) dp_mask = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if ({an, seg, frame_done, dec_din} !== {exp_an, exp_seg, exp_fd, snap}) begin
                errors++;
                $display("FAIL random k=%0d: got an=%b seg=%h fd=%b din=%h, want an=%b seg=%h fd=%b din=%h",
                         k, an, seg, frame_done, dec_din, exp_an, exp_seg, exp_fd, snap);
            end
        end
        rst  = 1'b1;
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; load = 1'b0;
        load_addr = 2'd0; load_data = 4'h0; dp_mask = 4'h0;
        test_reset();
        test_basic_scan();
        test_dp();
        test_snapshot();
        test_enable_drop();
        test_leading_zero();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
